mem_port_arbiter: RTL

- Shares one single-port, byte-wide RAM (256x8 style) between two requesters: the instruction-fetch port (IF stage) and the data port (MEM stage, driven from EX/MEM).
- Each request is sequenced as 1/2/4 byte beats, assembled big-endian, and completed with a one-cycle done pulse.
- Stall outputs feed the hazard unit, which freezes the PC and pipeline registers while an access is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM-side signals of the shared memory port arbiter.
// The arbiter connects through the slave modport. The pipeline and RAM connect through the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;

  logic              dm_req;
  logic              dm_rw;
  logic [1:0]        dm_size;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_done;
  logic              dm_err;

  logic              stall_if;
  logic              stall_dm;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done, dm_err, stall_if, stall_dm,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done, dm_err, stall_if, stall_dm,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide single-port RAM between the fetch port and the data port.
// Each access runs as 1, 2 or 4 big-endian byte beats and ends with a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input logic               CLK,
  input logic               CLR,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

  state_t        state;
  logic [1:0]    beat;
  logic [1:0]    last_beat;
  logic          rw_q;
  logic [31:0]   wsh;
  logic [31:0]   asm_q;
  logic [SW-1:0] starve;

  logic [1:0]    dm_last;
  logic [31:0]   dm_wfirst;
  logic          dm_mis;
  logic          grant_dm;
  logic [31:0]   rd_next;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W], bus.if_addr[1:0], bus.dm_addr[31:ADDR_W]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    dm_last   = 2'd3;
    dm_wfirst = bus.dm_wdata;
    case (bus.dm_size)
      2'b00: begin
        dm_last   = 2'd0;
        dm_wfirst = {bus.dm_wdata[7:0], 24'h0};
      end
      2'b01: begin
        dm_last   = 2'd1;
        dm_wfirst = {bus.dm_wdata[15:0], 16'h0};
      end
      default: ;
    endcase
  end

  assign dm_mis   = (bus.dm_size == 2'b01 && bus.dm_addr[0]) ||
                    (bus.dm_size[1] && bus.dm_addr[1:0] != 2'b00);
  assign grant_dm = bus.dm_req && (!bus.if_req || (int'(starve) < STARVE_MAX));
  assign rd_next  = {asm_q[23:0], bus.mem_rdata};

  // Stalls are gated by reset so that every output reads 0 while CLR is low.
  assign bus.stall_if = CLR & bus.if_req & ~bus.if_done;
  assign bus.stall_dm = CLR & bus.dm_req & ~bus.dm_done;

  // NOTE: sequential state uses non-blocking assignments only, so each register samples pre-edge values.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state         <= IDLE;
      beat          <= '0;
      last_beat     <= '0;
      rw_q          <= 1'b0;
      wsh           <= '0;
      asm_q         <= '0;
      starve        <= '0;
      bus.if_rdata  <= '0;
      bus.if_done   <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_done   <= 1'b0;
      bus.dm_err    <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      bus.dm_err  <= 1'b0;
      case (state)
        IDLE: begin
          beat  <= '0;
          asm_q <= '0;
          if (grant_dm) begin
            if (bus.if_req) starve <= starve + 1'b1;
            rw_q      <= bus.dm_rw;
            last_beat <= dm_last;
            if (dm_mis) begin
              // A misaligned request never touches the RAM.
              state        <= RESP;
              bus.dm_done  <= 1'b1;
              bus.dm_err   <= 1'b1;
              bus.dm_rdata <= '0;
            end else begin
              state         <= DATA;
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= bus.dm_rw;
              bus.mem_addr  <= bus.dm_addr[ADDR_W-1:0];
              bus.mem_wdata <= bus.dm_rw ? dm_wfirst[31:24] : 8'h00;
              wsh           <= {dm_wfirst[23:0], 8'h00};
            end
          end else if (bus.if_req) begin
            state         <= FETCH;
            starve        <= '0;
            rw_q          <= 1'b0;
            last_beat     <= 2'd3;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
            bus.mem_wdata <= 8'h00;
          end
        end

        DATA, FETCH: begin
          asm_q <= rd_next;
          beat  <= beat + 1'b1;
          if (beat == last_beat) begin
            state         <= RESP;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 8'h00;
            if (state == FETCH) begin
              bus.if_done  <= 1'b1;
              bus.if_rdata <= rd_next;
            end else begin
              bus.dm_done <= 1'b1;
              if (!rw_q) bus.dm_rdata <= rd_next;
            end
          end else begin
            bus.mem_addr  <= bus.mem_addr + 1'b1;
            bus.mem_wdata <= rw_q ? wsh[31:24] : 8'h00;
            wsh           <= {wsh[23:0], 8'h00};
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
